// File: rtl/nes_controller_reader_pkg.sv
// Shared types and constants for the NES controller reader.
// Contents: poll FSM state enum, button bit positions in the serial
// stream (A first), and widths of the phase timer and bit index.
package nes_controller_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    LOW    = 3'd2,
    HIGH   = 3'd3,
    UPDATE = 3'd4
  } nes_state_t;

  localparam int unsigned NUM_BUTTONS = 8;

  // Serial order of the buttons; also their index in the shift register
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned TIMER_W   = 13;
  localparam int unsigned BIT_IDX_W = 3;

endpackage

// File: rtl/nes_controller_reader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; both flops load RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Polls one NES serial controller on each frame_rate strobe and presents
// the eight buttons as registered, active-high levels held between polls.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   frame_rate             - one-cycle poll strobe (honoured only when idle)
//   ctrl_data              - serial data from pad, active-low, asynchronous
//   ctrl_latch, ctrl_clk   - controller latch and shift clock
//   button_*               - decoded buttons, 1 = pressed
//   buttons_valid          - one-cycle pulse when button outputs update
module nes_controller_reader
  import nes_controller_reader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 150
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_rate,
  input  logic ctrl_data,
  output logic ctrl_latch,
  output logic ctrl_clk,
  output logic button_a,
  output logic button_b,
  output logic button_select,
  output logic button_start,
  output logic button_up,
  output logic button_down,
  output logic button_left,
  output logic button_right,
  output logic buttons_valid
);

  localparam logic [TIMER_W-1:0]   LATCH_LAST = TIMER_W'(2 * HALF_PERIOD - 1);
  localparam logic [TIMER_W-1:0]   HALF_LAST  = TIMER_W'(HALF_PERIOD - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(NUM_BUTTONS - 1);

  nes_state_t                 state_q, state_d;
  logic [TIMER_W-1:0]         timer_q, timer_d;
  logic [BIT_IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [NUM_BUTTONS-1:0]     shift_q, shift_d;
  logic [NUM_BUTTONS-1:0]     buttons_q, buttons_d;
  logic                       ctrl_latch_q, ctrl_latch_d;
  logic                       ctrl_clk_q, ctrl_clk_d;
  logic                       valid_q, valid_d;
  logic                       data_sync;
  logic                       phase_done_c;

  // Pad data idles high (not pressed) out of reset
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ctrl_data),
    .q_o   (data_sync)
  );

  // Current phase has reached its final cycle
  always_comb begin
    phase_done_c = 1'b0;
    case (state_q)
      LATCH:    phase_done_c = (timer_q == LATCH_LAST);
      LOW,
      HIGH:     phase_done_c = (timer_q == HALF_LAST);
      default:  phase_done_c = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_rate) state_d = LATCH;
      LATCH:   if (phase_done_c) state_d = LOW;
      LOW:     if (phase_done_c) state_d = (bit_idx_q == LAST_BIT) ? UPDATE : HIGH;
      HIGH:    if (phase_done_c) state_d = LOW;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase timer, bit index and shift register
  always_comb begin
    timer_d   = timer_q + TIMER_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    // Timer restarts on every state entry and rests at zero while idle
    if ((state_d != state_q) || (state_q == IDLE)) begin
      timer_d = '0;
    end
    if ((state_q == IDLE) && (state_d == LATCH)) begin
      bit_idx_d = '0;
    end else if ((state_q == HIGH) && (state_d == LOW)) begin
      bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
    end
    if ((state_q == LOW) && phase_done_c) begin
      shift_d[bit_idx_q] = data_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Output decode; registered below, so pins lag the state by one cycle
  always_comb begin
    ctrl_latch_d = (state_q == LATCH);
    ctrl_clk_d   = (state_q == HIGH);
    valid_d      = (state_q == UPDATE);
    buttons_d    = buttons_q;
    if (state_q == UPDATE) begin
      buttons_d = ~shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_latch_q <= 1'b0;
      ctrl_clk_q   <= 1'b0;
      valid_q      <= 1'b0;
      buttons_q    <= '0;
    end else begin
      ctrl_latch_q <= ctrl_latch_d;
      ctrl_clk_q   <= ctrl_clk_d;
      valid_q      <= valid_d;
      buttons_q    <= buttons_d;
    end
  end

  assign ctrl_latch    = ctrl_latch_q;
  assign ctrl_clk      = ctrl_clk_q;
  assign buttons_valid = valid_q;
  assign button_a      = buttons_q[BTN_A];
  assign button_b      = buttons_q[BTN_B];
  assign button_select = buttons_q[BTN_SELECT];
  assign button_start  = buttons_q[BTN_START];
  assign button_up     = buttons_q[BTN_UP];
  assign button_down   = buttons_q[BTN_DOWN];
  assign button_left   = buttons_q[BTN_LEFT];
  assign button_right  = buttons_q[BTN_RIGHT];

endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Polls one NES-style serial game controller once per `frame_rate` strobe and presents the eight decoded buttons as parallel, active-high, registered levels. Sits directly upstream of `movement_FSM`: its `button_up/down/left/right` outputs drive that block's button inputs, and A/B/Start/Select feed attack and menu logic. One instance per player.

## Interface
- `HALF_PERIOD`, 150: clock cycles per controller half-bit phase (6 µs at 25 MHz); legal range 4..4095.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_rate` in 1: one-cycle poll strobe, shared with `movement_FSM`.
- `ctrl_data` in 1: serial data from controller, active-low, asynchronous to `clk`.
- `ctrl_latch` out 1: controller latch, active-high.
- `ctrl_clk` out 1: controller shift clock, active-high pulses.
- `button_a`, `button_b`, `button_select`, `button_start`, `button_up`, `button_down`, `button_left`, `button_right` out 1 each: active-high pressed, held between polls.
- `buttons_valid` out 1: one-cycle pulse when the button outputs update.

## Operation
- `ctrl_data` passes through a 2-flop synchronizer before any use.
- FSM states:
  - `IDLE`: `ctrl_latch=0`, `ctrl_clk=0`.
  - `LATCH`: `ctrl_latch=1` for 2·H cycles (H = `HALF_PERIOD`).
  - `LOW`: `ctrl_latch=0`, `ctrl_clk=0` for H cycles. On the last cycle, sample the synchronized data into `shift[bit_idx]`.
  - `HIGH`: `ctrl_clk=1` for H cycles. `bit_idx` increments on exit.
  - `UPDATE`: one cycle.
- Transitions:
  - `IDLE` → `LATCH` when `frame_rate=1`.
  - `LATCH` → `LOW` when the phase timer expires.
  - `LOW` → `HIGH` if `bit_idx<7`; `LOW` → `UPDATE` if `bit_idx==7`.
  - `HIGH` → `LOW` when the phase timer expires.
  - `UPDATE` → `IDLE`.
- Bit order in `shift[0..7]`: A, B, Select, Start, Up, Down, Left, Right.
- In `UPDATE`, every button output takes `~shift[i]`, and `buttons_valid=1` for that cycle only.
- `frame_rate` is ignored in every state except `IDLE`. There is no queuing; a missed strobe is dropped.
- Phase timer: 13-bit up-counter, cleared on every state entry; the phase ends when count == length−1. `bit_idx` is 3 bits and cleared on `LATCH` entry.
- A disconnected controller means `ctrl_data` is pulled high, so every button reads not-pressed. No error flag.
- No up/down or left/right conflict filtering; downstream priority applies.

## Timing
- Reset (async assert):
  - state = `IDLE`; timer, `bit_idx` and `shift` cleared.
  - `ctrl_latch=0`, `ctrl_clk=0`, all button outputs 0, `buttons_valid=0`.
  - Takes effect immediately, mid-poll included.
  - Synchronizer flops reset to 1 (not pressed).
- Reset deassertion: first poll starts on the first `frame_rate` sampled high after release.
- All outputs are registered; no combinational path from an input to an output.
- Relative to `frame_rate` sampled high at cycle 0:
  - `ctrl_latch` is high for cycles 1..2H.
  - Bit k (k=0..7) is sampled at cycle 2H + (2k+1)·H.
  - `ctrl_clk` is high for cycles 2H+(2k+1)·H+1 .. 2H+(2k+2)·H, k=0..6.
  - `buttons_valid` and the new button values appear at cycle 17H+1.
  - Total poll = 17H+2 cycles including `IDLE` re-entry; 2552 cycles at H=150, well inside one 60 Hz frame.
- Data must be stable at the pin ≥3 cycles before each sample cycle, which the synchronizer requires. The protocol guarantees ≥H−1.
- Button outputs hold their value from one `UPDATE` to the next.

## Structure
- Shared package (alongside `movement_state`): `nes_state_t` enum (`IDLE`, `LATCH`, `LOW`, `HIGH`, `UPDATE`) and button index constants `BTN_A=0` … `BTN_RIGHT=7`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with reset-value parameter, reused for every asynchronous pad input.

## Test plan
All scenarios use H=4 and a behavioural controller model that shifts an 8-bit active-low vector on `ctrl_latch` / `ctrl_clk` rising edges.

1. **Reset values.** Hold `rst_n=0`, pulse `frame_rate` → `ctrl_latch`, `ctrl_clk`, all buttons and `buttons_valid` stay 0. Release reset, then `frame_rate` at cycle 0 → `ctrl_latch` high cycles 1–8 exactly.
2. **Single press.** Model pressed = Right only (serial 0x7F, A first) → `buttons_valid` pulses at cycle 69; `button_right=1`, the other seven buttons 0.
3. **Multiple presses.** Model pressed = A, Up, Left (A, Up, Left bits driven 0) → at cycle 69, `button_a`, `button_up`, `button_left` = 1, the other five 0. Exactly 7 `ctrl_clk` pulses counted, each 4 cycles high.
4. **Strobes during a poll.** `frame_rate` re-asserted at cycles 10 and 40 → ignored; one `buttons_valid` only. A strobe at cycle 70 starts a new poll, with `ctrl_latch` rising at cycle 71.
5. **Disconnected controller.** `ctrl_data` held 1 after a poll that reported Up → next poll clears all eight buttons at its `buttons_valid`.
6. **Reset mid-poll.** `rst_n` asserted at cycle 30 with `ctrl_clk` high → `ctrl_clk` drops asynchronously, all buttons 0, no `buttons_valid`. The next `frame_rate` after release performs a full, correct poll.
